// File: rtl/id_ex_elastic_reg.sv
// ID/EX pipeline register with a two-entry elastic buffer (main M, skid S).
// Decode fields are extracted on load and EX/MEM/WB controls are zeroed on bubbles.
module id_ex_elastic_reg #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  input  logic [ADDR_W-1:0] sign_extended,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instruction,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Read1_o,
  output logic [DATA_W-1:0] Read2_o,
  output logic [ADDR_W-1:0] Pc_o,
  output logic [ADDR_W-1:0] Sign_ext_o,
  output logic [10:0]       alu_ctrl_data,
  output logic [REG_W-1:0]  write_reg,
  output logic [REG_W-1:0]  rn_o,
  output logic [REG_W-1:0]  rm_o,
  output logic [1:0]        AluOp_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic [ADDR_W-1:0] sext;
    logic [ADDR_W-1:0] pc;
    logic [10:0]       alu_ctrl;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [7:0]        ctrl;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bundle_t in_b, m_q, s_q;
  logic    m_valid, s_valid, in_ready_q;
  logic    m_valid_n, s_valid_n;
  logic    ld_m_from_s, ld_m_from_in, ld_s;
  logic    acc, con;
  logic    unused_instr_bits;

  assign unused_instr_bits = ^instruction[15:10];

  // Fields are decoded once here so both M and S store them pre-extracted.
  always_comb begin
    in_b.read1    = read1;
    in_b.read2    = read2;
    in_b.sext     = sign_extended;
    in_b.pc       = pc;
    in_b.alu_ctrl = instruction[31:21];
    in_b.rd       = instruction[0 +: REG_W];
    in_b.rn       = instruction[5 +: REG_W];
    in_b.rm       = instruction[16 +: REG_W];
    in_b.ctrl     = {alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg};
  end

  assign acc = in_valid & in_ready_q;
  assign con = m_valid & out_ready;

  always_comb begin
    m_valid_n    = m_valid;
    s_valid_n    = s_valid;
    ld_m_from_s  = 1'b0;
    ld_m_from_in = 1'b0;
    ld_s         = 1'b0;
    if (flush) begin
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else if (!m_valid || con) begin
      if (s_valid) begin
        // S is older than anything arriving now, so it always moves up first.
        ld_m_from_s = 1'b1;
        m_valid_n   = 1'b1;
        ld_s        = acc;
        s_valid_n   = acc;
      end else begin
        ld_m_from_in = acc;
        m_valid_n    = acc;
      end
    end else if (acc) begin
      ld_s      = 1'b1;
      s_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q          <= '0;
      s_q          <= '0;
      m_valid      <= 1'b0;
      s_valid      <= 1'b0;
      in_ready_q   <= 1'b1;
      bubble_count <= '0;
    end else begin
      m_valid    <= m_valid_n;
      s_valid    <= s_valid_n;
      in_ready_q <= ~s_valid_n;
      if (ld_m_from_s)
        m_q <= s_q;
      else if (ld_m_from_in)
        m_q <= in_b;
      if (ld_s)
        s_q <= in_b;
      if (out_ready && !m_valid && bubble_count != CNT_MAX)
        bubble_count <= bubble_count + 1'b1;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = m_valid;
  assign Read1_o       = m_q.read1;
  assign Read2_o       = m_q.read2;
  assign Pc_o          = m_q.pc;
  assign Sign_ext_o    = m_q.sext;
  assign alu_ctrl_data = m_q.alu_ctrl;
  assign write_reg     = m_q.rd;
  assign rn_o          = m_q.rn;
  assign rm_o          = m_q.rm;

  assign {AluOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o} =
    m_valid ? m_q.ctrl : 8'h00;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed table plus corner sequences and a scoreboarded random run for id_ex_elastic_reg.
module tb_id_ex_elastic_reg;

  logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] read1, read2, sign_extended, pc;
  logic [31:0] instruction;
  logic [1:0]  alu_op;
  logic        alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic [63:0] Read1_o, Read2_o, Pc_o, Sign_ext_o;
  logic [10:0] alu_ctrl_data;
  logic [4:0]  write_reg, rn_o, rm_o;
  logic [1:0]  AluOp_o;
  logic        ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o;
  logic [1:0]  bubble_count;
  logic [7:0]  ctrl_o;

  int checks = 0;
  int errors = 0;

  id_ex_elastic_reg #(.DATA_W(64), .ADDR_W(64), .REG_W(5), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .read1(read1), .read2(read2), .sign_extended(sign_extended), .pc(pc),
    .instruction(instruction), .alu_op(alu_op), .alu_src(alu_src),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .Read1_o(Read1_o), .Read2_o(Read2_o), .Pc_o(Pc_o), .Sign_ext_o(Sign_ext_o),
    .alu_ctrl_data(alu_ctrl_data), .write_reg(write_reg), .rn_o(rn_o), .rm_o(rm_o),
    .AluOp_o(AluOp_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .bubble_count(bubble_count)
  );

  assign ctrl_o = {AluOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv, ordy, fl;
    logic [63:0] pc;
    logic [7:0]  ctrl;
    logic        ov, ir, chk_pc;
    logic [63:0] pco;
    logic [7:0]  ctrlo;
  } vec_t;

  typedef struct {
    logic [63:0] pc, r1, r2, se;
    logic [31:0] instr;
    logic [7:0]  ctrl;
  } item_t;

  vec_t  vt[19];
  item_t sb[$];
  item_t cur, exp_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [63:0] p, input logic [31:0] ins, input logic [7:0] c);
    in_valid    = iv;
    pc          = p;
    instruction = ins;
    {alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg} = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] bub_exp [6];
    bit         have;
    logic [63:0] pc_ctr;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    read1 = '0; read2 = '0; sign_extended = '0;
    drive(1'b0, 64'h0, 32'h0, 8'h00);
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_pc_o", Pc_o, 64'd0);
    chk("rst_ctrl", {56'd0, ctrl_o}, 64'd0);
    chk("rst_bubble", {62'd0, bubble_count}, 64'd0);
    chk("rst_alu_ctrl", {53'd0, alu_ctrl_data}, 64'd0);
    step();
    reset = 1'b0;

    //          iv   ordy fl    pc     ctrl   ov   ir   chkpc pco    ctrlo
    vt[0]  = '{1'b1,1'b1,1'b0,64'h00,8'h11,1'b1,1'b1,1'b1,64'h00,8'h11};
    vt[1]  = '{1'b1,1'b1,1'b0,64'h04,8'h22,1'b1,1'b1,1'b1,64'h04,8'h22};
    vt[2]  = '{1'b1,1'b1,1'b0,64'h08,8'h33,1'b1,1'b1,1'b1,64'h08,8'h33};
    vt[3]  = '{1'b1,1'b1,1'b0,64'h0C,8'h44,1'b1,1'b1,1'b1,64'h0C,8'h44};
    vt[4]  = '{1'b0,1'b1,1'b0,64'h00,8'h00,1'b0,1'b1,1'b0,64'h00,8'h00};
    vt[5]  = '{1'b1,1'b1,1'b0,64'h10,8'h55,1'b1,1'b1,1'b1,64'h10,8'h55};
    vt[6]  = '{1'b1,1'b0,1'b0,64'h14,8'h66,1'b1,1'b0,1'b1,64'h10,8'h55};
    vt[7]  = '{1'b1,1'b0,1'b0,64'h18,8'h77,1'b1,1'b0,1'b1,64'h10,8'h55};
    vt[8]  = '{1'b1,1'b0,1'b0,64'h18,8'h77,1'b1,1'b0,1'b1,64'h10,8'h55};
    vt[9]  = '{1'b1,1'b1,1'b0,64'h18,8'h77,1'b1,1'b1,1'b1,64'h14,8'h66};
    vt[10] = '{1'b1,1'b1,1'b0,64'h18,8'h77,1'b1,1'b1,1'b1,64'h18,8'h77};
    vt[11] = '{1'b0,1'b1,1'b0,64'h00,8'h00,1'b0,1'b1,1'b0,64'h00,8'h00};
    vt[12] = '{1'b1,1'b0,1'b0,64'h20,8'h88,1'b1,1'b1,1'b1,64'h20,8'h88};
    vt[13] = '{1'b1,1'b0,1'b0,64'h24,8'h99,1'b1,1'b0,1'b1,64'h20,8'h88};
    vt[14] = '{1'b1,1'b1,1'b1,64'h28,8'hAA,1'b0,1'b1,1'b0,64'h00,8'h00};
    vt[15] = '{1'b1,1'b0,1'b0,64'h30,8'hBB,1'b1,1'b1,1'b1,64'h30,8'hBB};
    vt[16] = '{1'b1,1'b0,1'b1,64'h34,8'hCC,1'b0,1'b1,1'b0,64'h00,8'h00};
    vt[17] = '{1'b0,1'b1,1'b0,64'h00,8'h00,1'b0,1'b1,1'b0,64'h00,8'h00};
    vt[18] = '{1'b1,1'b1,1'b0,64'h38,8'hDD,1'b1,1'b1,1'b1,64'h38,8'hDD};

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].iv, vt[i].pc, 32'h0, vt[i].ctrl);
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      step();
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ov});
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].ir});
      chk($sformatf("vec%0d_ctrl", i), {56'd0, ctrl_o}, {56'd0, vt[i].ctrlo});
      if (vt[i].chk_pc)
        chk($sformatf("vec%0d_pc_o", i), Pc_o, vt[i].pco);
    end
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 8'h00);
    step();

    // Field extraction through M directly and through the skid entry.
    out_ready = 1'b0;
    drive(1'b1, 64'h50, 32'h8B020020, 8'h81);
    step();
    chk("add_alu_ctrl", {53'd0, alu_ctrl_data}, 64'h458);
    chk("add_write_reg", {59'd0, write_reg}, 64'd0);
    chk("add_rn", {59'd0, rn_o}, 64'd1);
    chk("add_rm", {59'd0, rm_o}, 64'd2);
    drive(1'b1, 64'h54, 32'hFFFFFFFF, 8'h7E);
    step();
    chk("skid_hold_alu_ctrl", {53'd0, alu_ctrl_data}, 64'h458);
    drive(1'b0, 64'h0, 32'h0, 8'h00);
    out_ready = 1'b1;
    step();
    chk("skid_pc", Pc_o, 64'h54);
    chk("skid_alu_ctrl", {53'd0, alu_ctrl_data}, 64'h7FF);
    chk("skid_write_reg", {59'd0, write_reg}, 64'd31);
    chk("skid_rn", {59'd0, rn_o}, 64'd31);
    chk("skid_rm", {59'd0, rm_o}, 64'd31);
    chk("skid_ctrl", {56'd0, ctrl_o}, 64'h7E);

    // Saturating bubble counter, then asynchronous reset mid-cycle.
    do_reset();
    bub_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bubble%0d", i), {62'd0, bubble_count}, {62'd0, bub_exp[i]});
    end
    out_ready = 1'b0;
    read1 = 64'hDEAD;
    drive(1'b1, 64'h40, 32'hFFFFFFFF, 8'hFF);
    step();
    chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 64'h44, 32'hFFFFFFFF, 8'hFF);
    step();
    chk("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    chk("async_pc_o", Pc_o, 64'd0);
    chk("async_read1", Read1_o, 64'd0);
    chk("async_fields", {37'd0, alu_ctrl_data, write_reg, rn_o, rm_o}, 64'd0);
    chk("async_ctrl", {56'd0, ctrl_o}, 64'd0);
    chk("async_bubble", {62'd0, bubble_count}, 64'd0);
    drive(1'b0, 64'h0, 32'h0, 8'h00);
    step();
    reset = 1'b0;
    step();
    read1 = '0;

    // Random valid/ready traffic against an in-order scoreboard.
    have = 1'b0;
    pc_ctr = 64'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        pc_ctr    = pc_ctr + 64'd4;
        cur.pc    = pc_ctr;
        cur.r1    = {$urandom, $urandom};
        cur.r2    = {$urandom, $urandom};
        cur.se    = {$urandom, $urandom};
        cur.instr = $urandom;
        cur.ctrl  = 8'($urandom_range(0, 255));
        have      = 1'b1;
      end
      in_valid = have;
      pc = cur.pc; read1 = cur.r1; read2 = cur.r2; sign_extended = cur.se;
      instruction = cur.instr;
      {alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg} = cur.ctrl;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("rnd_unexpected_output", Pc_o, 64'd0);
          end else begin
            exp_i = sb.pop_front();
            chk("rnd_pc", Pc_o, exp_i.pc);
            chk("rnd_read1", Read1_o, exp_i.r1);
            chk("rnd_read2", Read2_o, exp_i.r2);
            chk("rnd_sext", Sign_ext_o, exp_i.se);
            chk("rnd_alu_ctrl", {53'd0, alu_ctrl_data}, {53'd0, exp_i.instr[31:21]});
            chk("rnd_regs", {49'd0, write_reg, rn_o, rm_o},
                {49'd0, exp_i.instr[4:0], exp_i.instr[9:5], exp_i.instr[20:16]});
            chk("rnd_ctrl", {56'd0, ctrl_o}, {56'd0, exp_i.ctrl});
          end
        end
      end else begin
        chk("rnd_bubble_ctrl", {56'd0, ctrl_o}, 64'd0);
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        have = 1'b0;
      end
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_output", Pc_o, 64'd0);
        end else begin
          exp_i = sb.pop_front();
          chk("drain_pc", Pc_o, exp_i.pc);
        end
      end
      step();
    end
    chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
